vdc_ram_scheduler: RTL and testbench

VDC_RAM_SCHEDULER -- requirements
Module: vdc_ram_scheduler

---
 rtl/vdc_ram_scheduler.sv | 179 +++++++++++++++++
 tb/tb_vdc_ram_scheduler.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdc_ram_scheduler.sv
// +--------------------------------------------------------------------------+
// | vdc_ram_scheduler                                                        |
// | Per-slot video RAM scheduler: refresh/char/attr/font phases, then CPU    |
// | and block-copy arbitration in the free part of the line.                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module vdc_ram_scheduler (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       lineStart,
    input  logic       fetchRow,
    input  logic       fetchLine,
    input  logic [7:0] reg_hd,
    input  logic       reg_atr,
    input  logic [3:0] reg_rfc,
    input  logic       cpu_req,
    input  logic       blk_start,
    input  logic [7:0] blk_len,
    output logic [2:0] slot_type,
    output logic [7:0] slot_idx,
    output logic       cpu_ack,
    output logic       blk_busy,
    output logic       overrun
);

    typedef enum logic [2:0] {
        PH_REFRESH = 3'd0,
        PH_CHAR    = 3'd1,
        PH_ATTR    = 3'd2,
        PH_FONT    = 3'd3,
        PH_FREE    = 3'd4
    } phase_t;

    localparam logic [2:0] C_ST_IDLE    = 3'd0;
    localparam logic [2:0] C_ST_REFRESH = 3'd1;
    localparam logic [2:0] C_ST_CHAR    = 3'd2;
    localparam logic [2:0] C_ST_ATTR    = 3'd3;
    localparam logic [2:0] C_ST_FONT    = 3'd4;
    localparam logic [2:0] C_ST_CPU     = 3'd5;
    localparam logic [2:0] C_ST_BLOCK   = 3'd6;

    phase_t     phase_q, phase_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] len_q, len_d;
    logic       row_q, row_d;
    logic       line_q, line_d;
    logic [2:0] slot_type_q, slot_type_d;
    logic       cpu_ack_q, cpu_ack_d;
    logic       overrun_q, overrun_d;
    logic       blk_busy_q, blk_busy_d;
    logic [8:0] blk_cnt_q, blk_cnt_d;

    logic       w_hd_nz;
    logic [3:0] w_elig;
    logic [3:0] w_after_mask;
    logic [3:0] w_cand;
    logic       w_last;
    phase_t     w_pick;
    logic       w_blk_grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q     <= PH_FREE;
            idx_q       <= 8'd0;
            len_q       <= 8'd0;
            row_q       <= 1'b0;
            line_q      <= 1'b0;
            slot_type_q <= C_ST_IDLE;
            cpu_ack_q   <= 1'b0;
            overrun_q   <= 1'b0;
            blk_busy_q  <= 1'b0;
            blk_cnt_q   <= 9'd0;
        end else if (enable) begin
            phase_q     <= phase_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            row_q       <= row_d;
            line_q      <= line_d;
            slot_type_q <= slot_type_d;
            cpu_ack_q   <= cpu_ack_d;
            overrun_q   <= overrun_d;
            blk_busy_q  <= blk_busy_d;
            blk_cnt_q   <= blk_cnt_d;
        end
    end

    always_comb begin
        row_d       = row_q;
        line_d      = line_q;
        phase_d     = phase_q;
        idx_d       = idx_q;
        len_d       = len_q;
        slot_type_d = C_ST_IDLE;
        cpu_ack_d   = 1'b0;
        overrun_d   = 1'b0;
        blk_busy_d  = blk_busy_q;
        blk_cnt_d   = blk_cnt_q;
        w_blk_grant = 1'b0;
        w_pick      = PH_FREE;

        if (lineStart) begin
            row_d  = fetchRow;
            line_d = fetchLine;
        end

        // Eligibility bits in phase order {FONT, ATTR, CHAR, REFRESH}.
        w_hd_nz = (reg_hd != 8'd0);
        w_elig  = {line_d & w_hd_nz, row_d & reg_atr & w_hd_nz,
                   row_d & w_hd_nz, (reg_rfc != 4'd0)};

        case (phase_q)
            PH_REFRESH: w_after_mask = 4'b1110;
            PH_CHAR:    w_after_mask = 4'b1100;
            PH_ATTR:    w_after_mask = 4'b1000;
            default:    w_after_mask = 4'b0000;
        endcase

        w_last = (phase_q != PH_FREE) &&
                 (({1'b0, idx_q} + 9'd1) == {1'b0, len_q});
        w_cand = lineStart ? w_elig : (w_elig & w_after_mask);

        if (w_cand[0])      w_pick = PH_REFRESH;
        else if (w_cand[1]) w_pick = PH_CHAR;
        else if (w_cand[2]) w_pick = PH_ATTR;
        else if (w_cand[3]) w_pick = PH_FONT;
        else                w_pick = PH_FREE;

        // Lengths are captured at phase entry so mid-phase register writes
        // only affect later phases.
        if (lineStart || w_last) begin
            phase_d = w_pick;
            idx_d   = 8'd0;
            len_d   = (w_pick == PH_REFRESH) ? {4'd0, reg_rfc} : reg_hd;
        end else if (phase_q != PH_FREE) begin
            idx_d = idx_q + 8'd1;
        end

        overrun_d = lineStart && (phase_q != PH_FREE);

        case (phase_d)
            PH_REFRESH: slot_type_d = C_ST_REFRESH;
            PH_CHAR:    slot_type_d = C_ST_CHAR;
            PH_ATTR:    slot_type_d = C_ST_ATTR;
            PH_FONT:    slot_type_d = C_ST_FONT;
            default: begin
                if (cpu_req) begin
                    slot_type_d = C_ST_CPU;
                    cpu_ack_d   = 1'b1;
                end else if (blk_busy_q) begin
                    slot_type_d = C_ST_BLOCK;
                    w_blk_grant = 1'b1;
                end else begin
                    slot_type_d = C_ST_IDLE;
                end
            end
        endcase

        // A new start reloads the counter even when this slot is a block slot.
        if (blk_start) begin
            blk_cnt_d  = (blk_len == 8'd0) ? 9'd256 : {1'b0, blk_len};
            blk_busy_d = 1'b1;
        end else if (w_blk_grant) begin
            blk_cnt_d  = blk_cnt_q - 9'd1;
            blk_busy_d = (blk_cnt_q != 9'd1);
        end
    end

    assign slot_type = slot_type_q;
    assign slot_idx  = idx_q;
    assign cpu_ack   = cpu_ack_q;
    assign blk_busy  = blk_busy_q;
    assign overrun   = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_vdc_ram_scheduler.sv
// +--------------------------------------------------------------------------+
// | tb_vdc_ram_scheduler                                                     |
// | Self-checking bench: vector table, directed line sequences, random run.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_vdc_ram_scheduler;

    localparam logic [2:0] C_IDLE = 3'd0, C_REF = 3'd1, C_CHR = 3'd2, C_ATR = 3'd3,
                           C_FNT = 3'd4, C_CPU = 3'd5, C_BLK = 3'd6;

    logic       clk = 1'b0;
    logic       rst = 1'b0, en = 1'b1, ls = 1'b0, frow = 1'b0, fline = 1'b0;
    logic [7:0] hd = 8'd0;
    logic       atr = 1'b0;
    logic [3:0] rfc = 4'd0;
    logic       creq = 1'b0, bstart = 1'b0;
    logic [7:0] blen = 8'd0;
    logic [2:0] slot_type;
    logic [7:0] slot_idx;
    logic       cpu_ack, blk_busy, overrun;

    int n_chk = 0;
    int n_fail = 0;

    vdc_ram_scheduler dut (
        .clk(clk), .reset(rst), .enable(en), .lineStart(ls), .fetchRow(frow),
        .fetchLine(fline), .reg_hd(hd), .reg_atr(atr), .reg_rfc(rfc),
        .cpu_req(creq), .blk_start(bstart), .blk_len(blen),
        .slot_type(slot_type), .slot_idx(slot_idx), .cpu_ack(cpu_ack),
        .blk_busy(blk_busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Reference model: a line is expanded into a queue of slots at lineStart.
    typedef struct { logic [2:0] t; logic [7:0] i; } slot_t;
    slot_t      m_q[$];
    logic       m_active = 1'b0;
    logic [2:0] m_type = 3'd0;
    logic [7:0] m_idx = 8'd0;
    logic       m_ack = 1'b0, m_busy = 1'b0, m_ov = 1'b0;
    int         m_cnt = 0;

    task automatic push_phase(input logic [2:0] t, input int n);
        for (int k = 0; k < n; k++) m_q.push_back('{t: t, i: 8'(k)});
    endtask

    task automatic model_step();
        slot_t s;
        logic  busy_before;
        if (rst) begin
            m_q.delete();
            m_active = 0; m_type = C_IDLE; m_idx = 0; m_ack = 0;
            m_busy = 0; m_ov = 0; m_cnt = 0;
        end else if (en) begin
            m_ov = ls && m_active;
            if (ls) begin
                m_q.delete();
                push_phase(C_REF, int'(rfc));
                if (frow) push_phase(C_CHR, int'(hd));
                if (frow && atr) push_phase(C_ATR, int'(hd));
                if (fline) push_phase(C_FNT, int'(hd));
            end
            busy_before = m_busy;
            m_ack = 0;
            if (m_q.size() > 0) begin
                s = m_q.pop_front();
                m_type = s.t; m_idx = s.i; m_active = 1;
            end else begin
                m_active = 0; m_idx = 0;
                if (creq) begin m_type = C_CPU; m_ack = 1; end
                else if (busy_before) m_type = C_BLK;
                else m_type = C_IDLE;
            end
            if (bstart) begin
                m_cnt = (blen == 0) ? 256 : int'(blen);
                m_busy = 1;
            end else if (!m_active && m_type == C_BLK) begin
                m_cnt = m_cnt - 1;
                m_busy = (m_cnt != 0);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_slot(input string name, input logic [2:0] t, input logic [7:0] i);
        chk({name, ".type"}, int'(slot_type), int'(t));
        chk({name, ".idx"}, int'(slot_idx), int'(i));
    endtask

    task automatic do_reset();
        rst = 1; ls = 0; creq = 0; bstart = 0; en = 1;
        tick();
        rst = 0;
    endtask

    typedef struct packed {
        logic       rst, en, ls, frow, fline, creq, bstart;
        logic [7:0] blen;
        logic [2:0] et;
        logic [7:0] ei;
        logic       eack, ebusy, eov;
    } vec_t;

    vec_t tbl[14];

    initial begin
        //            rst en ls fr fl cq bs blen  type   idx  ack busy ov
        tbl[0]  = '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,8'd0, C_IDLE,8'd0,1'b0,1'b0,1'b0};
        tbl[1]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,8'd2, C_IDLE,8'd0,1'b0,1'b1,1'b0};
        tbl[2]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,8'd0, C_CPU, 8'd0,1'b1,1'b1,1'b0};
        tbl[3]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,8'd0, C_CPU, 8'd0,1'b1,1'b1,1'b0};
        tbl[4]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,8'd0, C_BLK, 8'd0,1'b0,1'b1,1'b0};
        tbl[5]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,8'd0, C_REF, 8'd0,1'b0,1'b1,1'b0};
        tbl[6]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,8'd0, C_REF, 8'd1,1'b0,1'b1,1'b0};
        tbl[7]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,8'd0, C_CHR, 8'd0,1'b0,1'b1,1'b0};
        tbl[8]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,8'd0, C_CPU, 8'd0,1'b1,1'b1,1'b0};
        tbl[9]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,8'd0, C_BLK, 8'd0,1'b0,1'b0,1'b0};
        tbl[10] = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,8'd0, C_IDLE,8'd0,1'b0,1'b0,1'b0};
        tbl[11] = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,8'd0, C_REF, 8'd0,1'b0,1'b0,1'b0};
        tbl[12] = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,8'd0, C_REF, 8'd0,1'b0,1'b0,1'b1};
        tbl[13] = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,8'd0, C_REF, 8'd1,1'b0,1'b0,1'b0};

        // Table section: rfc=2, hd=1, no attributes.
        rfc = 4'd2; hd = 8'd1; atr = 1'b0;
        for (int v = 0; v < 14; v++) begin
            rst = tbl[v].rst; en = tbl[v].en; ls = tbl[v].ls; frow = tbl[v].frow;
            fline = tbl[v].fline; creq = tbl[v].creq; bstart = tbl[v].bstart;
            blen = tbl[v].blen;
            tick();
            chk($sformatf("vec%0d.type", v), int'(slot_type), int'(tbl[v].et));
            chk($sformatf("vec%0d.idx", v), int'(slot_idx), int'(tbl[v].ei));
            chk($sformatf("vec%0d.ack", v), int'(cpu_ack), int'(tbl[v].eack));
            chk($sformatf("vec%0d.busy", v), int'(blk_busy), int'(tbl[v].ebusy));
            chk($sformatf("vec%0d.ov", v), int'(overrun), int'(tbl[v].eov));
        end
        en = 1; ls = 0; creq = 0; bstart = 0;

        // Full line: 5 refresh + 80 char + 80 attr + 80 font, FREE at slot 245.
        do_reset();
        rfc = 4'd5; hd = 8'd80; atr = 1; frow = 1; fline = 1; ls = 1;
        tick();
        ls = 0;
        for (int s = 0; s < 245; s++) begin
            if (s < 5)       chk_slot($sformatf("full%0d", s), C_REF, 8'(s));
            else if (s < 85) chk_slot($sformatf("full%0d", s), C_CHR, 8'(s - 5));
            else if (s < 165) chk_slot($sformatf("full%0d", s), C_ATR, 8'(s - 85));
            else             chk_slot($sformatf("full%0d", s), C_FNT, 8'(s - 165));
            tick();
        end
        chk_slot("full245", C_IDLE, 8'd0);
        tick();
        chk_slot("full246", C_IDLE, 8'd0);

        // Font-only line with refresh disabled.
        do_reset();
        rfc = 4'd0; hd = 8'd40; atr = 0; frow = 0; fline = 1; ls = 1;
        tick();
        ls = 0;
        for (int s = 0; s < 40; s++) begin
            chk_slot($sformatf("font%0d", s), C_FNT, 8'(s));
            tick();
        end
        chk_slot("font_free", C_IDLE, 8'd0);

        // CPU request during CHAR with a block pending.
        do_reset();
        rfc = 4'd0; hd = 8'd8; atr = 0; frow = 1; fline = 0;
        bstart = 1; blen = 8'd10;
        tick();
        chk("cpu.busy_set", int'(blk_busy), 1);
        bstart = 0; ls = 1; creq = 1;
        tick();
        ls = 0;
        for (int s = 0; s < 8; s++) begin
            chk_slot($sformatf("cpuchar%0d", s), C_CHR, 8'(s));
            chk($sformatf("cpuchar%0d.ack", s), int'(cpu_ack), 0);
            if (s < 7) tick();
        end
        tick();
        chk_slot("cpu.first_free", C_CPU, 8'd0);
        chk("cpu.first_ack", int'(cpu_ack), 1);
        creq = 0;
        tick();
        chk_slot("cpu.blk0", C_BLK, 8'd0);
        chk("cpu.blk0.ack", int'(cpu_ack), 0);
        tick();
        chk_slot("cpu.blk1", C_BLK, 8'd0);

        // Block of 256 words (blk_len = 0).
        do_reset();
        bstart = 1; blen = 8'd0;
        tick();
        chk("blk256.busy_set", int'(blk_busy), 1);
        bstart = 0;
        for (int s = 0; s < 256; s++) begin
            tick();
            chk($sformatf("blk256.%0d.type", s), int'(slot_type), int'(C_BLK));
            chk($sformatf("blk256.%0d.busy", s), int'(blk_busy), (s != 255) ? 1 : 0);
        end
        tick();
        chk_slot("blk256.after", C_IDLE, 8'd0);
        chk("blk256.after.busy", int'(blk_busy), 0);

        // Overrun at FONT idx 10, none from FREE.
        do_reset();
        rfc = 4'd3; hd = 8'd20; atr = 0; frow = 0; fline = 1; ls = 1;
        tick();
        ls = 0;
        for (int s = 0; s < 13; s++) tick();
        chk_slot("ovr.font10", C_FNT, 8'd10);
        ls = 1;
        tick();
        ls = 0;
        chk_slot("ovr.restart", C_REF, 8'd0);
        chk("ovr.pulse", int'(overrun), 1);
        tick();
        chk_slot("ovr.next", C_REF, 8'd1);
        chk("ovr.pulse_end", int'(overrun), 0);
        for (int s = 0; s < 22; s++) tick();
        chk_slot("ovr.free", C_IDLE, 8'd0);
        ls = 1;
        tick();
        ls = 0;
        chk_slot("ovr.free_start", C_REF, 8'd0);
        chk("ovr.free_nopulse", int'(overrun), 0);

        // Reset mid-ATTR with a block pending and a CPU request present.
        do_reset();
        rfc = 4'd0; hd = 8'd10; atr = 1; frow = 1; fline = 0;
        bstart = 1; blen = 8'd50;
        tick();
        bstart = 0; ls = 1;
        tick();
        ls = 0;
        for (int s = 0; s < 13; s++) tick();
        chk_slot("rst.attr3", C_ATR, 8'd3);
        chk("rst.attr3.busy", int'(blk_busy), 1);
        rst = 1; creq = 1;
        tick();
        chk_slot("rst.cycle", C_IDLE, 8'd0);
        chk("rst.cycle.ack", int'(cpu_ack), 0);
        chk("rst.cycle.busy", int'(blk_busy), 0);
        rst = 0; creq = 0;
        tick();
        chk_slot("rst.after", C_IDLE, 8'd0);
        chk("rst.after.busy", int'(blk_busy), 0);
        chk("rst.after.ack", int'(cpu_ack), 0);

        // Randomized run against the queue model.
        do_reset();
        for (int c = 0; c < 6000; c++) begin
            rst    = ($urandom_range(0, 799) == 0);
            en     = ($urandom_range(0, 9) != 0);
            ls     = ($urandom_range(0, 59) == 0);
            frow   = 1'($urandom_range(0, 1));
            fline  = 1'($urandom_range(0, 1));
            creq   = ($urandom_range(0, 3) == 0);
            bstart = ($urandom_range(0, 99) == 0);
            blen   = 8'($urandom_range(0, 30));
            if (ls && en) begin
                hd  = 8'($urandom_range(0, 12));
                rfc = 4'($urandom_range(0, 15));
                atr = 1'($urandom_range(0, 1));
            end
            tick();
            chk("rnd.type", int'(slot_type), int'(m_type));
            chk("rnd.idx", int'(slot_idx), int'(m_idx));
            chk("rnd.ack", int'(cpu_ack), int'(m_ack));
            chk("rnd.busy", int'(blk_busy), int'(m_busy));
            chk("rnd.ov", int'(overrun), int'(m_ov));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
